// File: rtl/hdc_pkg.sv
// Shared constants and types for the LBP front-end of the dense HDC classifier.
// Channel count, code length and sample width are fixed here for the whole slice.
package hdc_pkg;

  localparam int E          = 64;
  localparam int LBP_LENGTH = 6;
  localparam int SAMPLE_W   = 16;
  localparam int CH_IDX_W   = $clog2(E);
  localparam int DROP_CNT_W = 16;

  typedef logic [LBP_LENGTH-1:0] lbp_code_t;
  typedef lbp_code_t [E-1:0] lbp_frame_t;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } lbp_state_e;

endpackage

// File: rtl/lbp_out_buffer.sv
// Output frame holding register with valid flag; consumed by send_next_LBP.
// Latency: load visible next cycle. Overflow: with LBP_DROP_EN an unconsumed frame is
// overwritten and counted (saturating); otherwise the producer must never overwrite.
module lbp_out_buffer
  import hdc_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  arst_n_in,
  input  logic                  load,
  input  logic                  send_next_LBP,
  input  lbp_frame_t            frame_d,
  output logic                  lbp_valid_o,
  output lbp_frame_t            frame_q,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  logic consume;

  assign consume = lbp_valid_o & send_next_LBP;

  // A load in the same cycle as a consume keeps valid high with no bubble.
  always_ff @(posedge clk_i or negedge arst_n_in) begin
    if (!arst_n_in) begin
      lbp_valid_o <= 1'b0;
      frame_q     <= '0;
    end else if (load) begin
      lbp_valid_o <= 1'b1;
      frame_q     <= frame_d;
    end else if (consume) begin
      lbp_valid_o <= 1'b0;
    end
  end

`ifdef LBP_DROP_EN
  always_ff @(posedge clk_i or negedge arst_n_in) begin
    if (!arst_n_in) begin
      drop_cnt_o <= '0;
    end else if (load && lbp_valid_o && !send_next_LBP && (drop_cnt_o != '1)) begin
      drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
    end
  end
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: rtl/lbp_code_gen.sv
// Per-channel LBP code generator over a time-multiplexed sample stream (build option LBP_DROP_EN).
// Latency: frame valid 1 cycle after ch E-1 is accepted. Backpressure: stalls only ch E-1 while
// an unconsumed frame is held (default); with LBP_DROP_EN never stalls and drops old frames.
module lbp_code_gen
  import hdc_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       arst_n_in,
  input  logic                       sample_valid_i,
  input  logic [SAMPLE_W-1:0]        sample_i,
  output logic                       sample_ready_o,
  input  logic                       send_next_LBP,
  output logic                       lbp_valid_o,
  output logic [E*LBP_LENGTH-1:0]    LBP_codes_o,
  output logic                       frame_start_o,
  output logic [DROP_CNT_W-1:0]      drop_cnt_o
);

  localparam int WARM_W = $clog2(LBP_LENGTH + 2);
  localparam logic [0:0] ST_WARMUP = WARMUP;
  localparam logic [0:0] ST_RUN    = RUN;

  logic [CH_IDX_W-1:0] ch_idx;
  logic [0:0]          state;
  logic [WARM_W-1:0]   warm_cnt;
  logic [SAMPLE_W-1:0] prev_q [E];
  lbp_frame_t          code_q;
  lbp_frame_t          code_d;
  lbp_frame_t          frame_q;
  logic                last_ch;
  logic                accept;
  logic                frame_done;
  logic                load;
  logic                cmp_bit;

  assign last_ch = (ch_idx == CH_IDX_W'(E - 1));

`ifdef LBP_DROP_EN
  assign sample_ready_o = 1'b1;
`else
  assign sample_ready_o = !(last_ch && (state == ST_RUN) && lbp_valid_o && !send_next_LBP);
`endif

  assign accept     = sample_valid_i & sample_ready_o;
  assign frame_done = accept & last_ch;
  assign cmp_bit    = $signed(sample_i) > $signed(prev_q[ch_idx]);

  // The frame that completes warm-up is already the first meaningful one, so it loads too.
  assign load = frame_done & ((state == ST_RUN) | (warm_cnt == WARM_W'(LBP_LENGTH)));

  always_comb begin
    code_d         = code_q;
    code_d[ch_idx] = {code_q[ch_idx][LBP_LENGTH-2:0], cmp_bit};
  end

  always_ff @(posedge clk_i or negedge arst_n_in) begin
    if (!arst_n_in) begin
      ch_idx        <= '0;
      frame_start_o <= 1'b1;
      code_q        <= '0;
      for (int c = 0; c < E; c++) begin
        prev_q[c] <= '0;
      end
    end else if (accept) begin
      ch_idx         <= ch_idx + CH_IDX_W'(1);
      frame_start_o  <= last_ch;
      code_q         <= code_d;
      prev_q[ch_idx] <= sample_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state    <= ST_WARMUP;
      warm_cnt <= '0;
    end else if (frame_done && (state == ST_WARMUP)) begin
      warm_cnt <= warm_cnt + WARM_W'(1);
      if (warm_cnt == WARM_W'(LBP_LENGTH)) begin
        state <= ST_RUN;
      end
    end
  end

  lbp_out_buffer u_out_buffer (
    .clk_i         (clk_i),
    .arst_n_in     (arst_n_in),
    .load          (load),
    .send_next_LBP (send_next_LBP),
    .frame_d       (code_d),
    .lbp_valid_o   (lbp_valid_o),
    .frame_q       (frame_q),
    .drop_cnt_o    (drop_cnt_o)
  );

  assign LBP_codes_o = frame_q;

endmodule

// File: tb/tb_lbp_code_gen.sv
// Self-checking bench for lbp_code_gen: random and patterned sample streams against a
// history-based reference model (codes recomputed from the last LBP_LENGTH frame pairs).
module tb_lbp_code_gen;

  localparam int E = 64;
  localparam int L = 6;

  typedef logic signed [15:0] frame_t [E];

  logic             clk_i = 1'b0;
  logic             arst_n_in = 1'b0;
  logic             sample_valid_i = 1'b0;
  logic [15:0]      sample_i = '0;
  logic             send_next_LBP = 1'b0;
  logic             sample_ready_o;
  logic             lbp_valid_o;
  logic [E*L-1:0]   LBP_codes_o;
  logic             frame_start_o;
  logic [15:0]      drop_cnt_o;

  int     n_tests = 0;
  int     n_fail  = 0;
  frame_t hist[$];
  bit     exp_valid;
  int     exp_idx;
  int     exp_drop;

  always #5 clk_i = ~clk_i;

  lbp_code_gen dut (
    .clk_i          (clk_i),
    .arst_n_in      (arst_n_in),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .sample_ready_o (sample_ready_o),
    .send_next_LBP  (send_next_LBP),
    .lbp_valid_o    (lbp_valid_o),
    .LBP_codes_o    (LBP_codes_o),
    .frame_start_o  (frame_start_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  // Expected code of every channel after frame f: one bit per sample-vs-previous comparison
  // over the last L frames, oldest comparison in the MSB; the sample before frame 0 is 0.
  function automatic logic [E*L-1:0] exp_frame(input int f);
    logic [E*L-1:0]    r;
    logic [L-1:0]      code;
    logic signed [15:0] cur;
    logic signed [15:0] prv;
    r = '0;
    for (int c = 0; c < E; c++) begin
      code = '0;
      for (int k = f - L + 1; k <= f; k++) begin
        cur  = hist[k][c];
        prv  = (k == 0) ? 16'sd0 : hist[k-1][c];
        code = {code[L-2:0], (cur > prv)};
      end
      r[c*L +: L] = code;
    end
    return r;
  endfunction

  task automatic clear_model();
    hist.delete();
    exp_valid = 1'b0;
    exp_idx   = 0;
    exp_drop  = 0;
  endtask

  task automatic note_frame(input frame_t s, input bit consumed);
    hist.push_back(s);
    if (hist.size() >= L + 1) begin
      if (exp_valid && !consumed && exp_drop < 65535) exp_drop++;
      exp_valid = 1'b1;
      exp_idx   = hist.size() - 1;
    end
  endtask

  task automatic do_reset();
    sample_valid_i = 1'b0;
    send_next_LBP  = 1'b0;
    arst_n_in      = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    arst_n_in = 1'b1;
    @(posedge clk_i);
    #1;
    clear_model();
  endtask

  // kind 0: random, 1: ramp, 2: decreasing then constant, 3: alternating +/-100
  task automatic gen_frame(input int kind, input int t, output frame_t f);
    int x;
    for (int c = 0; c < E; c++) begin
      case (kind)
        1:       x = t;
        2:       x = ((t < 3) ? (1000 - 100 * t) : 700) - c;
        3:       x = (t % 2 == 0) ? 100 : -100;
        default: x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                                  : int'($urandom_range(0, 15)) - 8;
      endcase
      f[c] = 16'(x);
    end
  endtask

  // Starts and ends #1 after a rising edge; presents one sample until accepted or max_wait.
  task automatic put_sample(input logic [15:0] v, input bit snd, input int max_wait,
                            output bit acc, output int waited);
    acc = 1'b0;
    waited = 0;
    sample_valid_i = 1'b1;
    sample_i       = v;
    send_next_LBP  = snd;
    while (!acc && waited < max_wait) begin
      @(negedge clk_i);
      if (sample_ready_o) acc = 1'b1;
      else waited++;
      @(posedge clk_i);
      #1;
    end
    sample_valid_i = 1'b0;
    send_next_LBP  = 1'b0;
  endtask

  task automatic send_frame(input frame_t s, input bit consume_last, output int stalls);
    bit acc;
    int w;
    stalls = 0;
    for (int c = 0; c < E; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk_i);
        #1;
      end
      n_tests++;
      if (frame_start_o !== (c == 0)) begin
        n_fail++;
        $display("FAIL frame_start ch%0d: got %b want %b", c, frame_start_o, (c == 0));
      end
      put_sample(s[c], (c == E - 1) && consume_last, 200, acc, w);
      stalls += w;
      n_tests++;
      if (acc !== 1'b1) begin
        n_fail++;
        $display("FAIL accept_timeout ch%0d: accepted %b want 1", c, acc);
      end
    end
    note_frame(s, consume_last);
  endtask

  task automatic pulse_consume();
    send_next_LBP = 1'b1;
    @(posedge clk_i);
    #1;
    send_next_LBP = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic test_reset();
    frame_t f;
    bit acc;
    int w;
    int st;
    repeat (2) @(posedge clk_i);
    #1;
    n_tests += 5;
    if (sample_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", sample_ready_o); end
    if (frame_start_o !== 1'b1) begin n_fail++; $display("FAIL rst_frame_start: got %b want 1", frame_start_o); end
    if (lbp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", lbp_valid_o); end
    if (LBP_codes_o !== '0) begin n_fail++; $display("FAIL rst_codes: got %h want 0", LBP_codes_o); end
    if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_drop: got %0d want 0", drop_cnt_o); end
    @(negedge clk_i);
    arst_n_in = 1'b1;
    @(posedge clk_i);
    #1;
    clear_model();
    // two warm-up frames plus a partial frame, then an asynchronous reset at ch 17
    for (int t = 0; t < 2; t++) begin
      gen_frame(0, t, f);
      send_frame(f, 1'b0, st);
    end
    gen_frame(0, 2, f);
    for (int c = 0; c < 17; c++) put_sample(f[c], 1'b0, 5, acc, w);
    n_tests++;
    if (frame_start_o !== 1'b0) begin n_fail++; $display("FAIL midframe_start: got %b want 0", frame_start_o); end
    sample_valid_i = 1'b1;
    sample_i       = f[17];
    arst_n_in      = 1'b0;
    #2;
    n_tests += 4;
    if (sample_ready_o !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", sample_ready_o); end
    if (frame_start_o !== 1'b1) begin n_fail++; $display("FAIL arst_frame_start: got %b want 1", frame_start_o); end
    if (lbp_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", lbp_valid_o); end
    if (LBP_codes_o !== '0) begin n_fail++; $display("FAIL arst_codes: got %h want 0", LBP_codes_o); end
    sample_valid_i = 1'b0;
    @(negedge clk_i);
    arst_n_in = 1'b1;
    @(posedge clk_i);
    #1;
    clear_model();
    // warm-up restarts from zero: only the 7th full frame yields output
    for (int t = 0; t <= L; t++) begin
      gen_frame(0, t, f);
      send_frame(f, 1'b0, st);
      n_tests++;
      if (lbp_valid_o !== (t == L)) begin
        n_fail++;
        $display("FAIL warmup_valid frame%0d: got %b want %b", t + 1, lbp_valid_o, (t == L));
      end
    end
    n_tests++;
    if (LBP_codes_o !== exp_frame(L)) begin
      n_fail++;
      $display("FAIL warmup_codes: got %h want %h", LBP_codes_o, exp_frame(L));
    end
  endtask

  task automatic test_ramp();
    frame_t f;
    int st;
    do_reset();
    for (int t = 0; t <= L; t++) begin
      gen_frame(1, t, f);
      send_frame(f, 1'b0, st);
    end
    n_tests += 2;
    if (lbp_valid_o !== 1'b1) begin n_fail++; $display("FAIL ramp_valid: got %b want 1", lbp_valid_o); end
    if (LBP_codes_o !== {E{6'h3F}}) begin n_fail++; $display("FAIL ramp_codes: got %h want all 3f", LBP_codes_o); end
    pulse_consume();
    n_tests++;
    if (lbp_valid_o !== 1'b0) begin n_fail++; $display("FAIL ramp_consume: got %b want 0", lbp_valid_o); end
    pulse_consume();
    n_tests++;
    if (LBP_codes_o !== {E{6'h3F}}) begin n_fail++; $display("FAIL ramp_hold_after_consume: got %h want all 3f", LBP_codes_o); end
  endtask

  task automatic test_decreasing();
    frame_t f;
    int st;
    do_reset();
    for (int t = 0; t <= L; t++) begin
      gen_frame(2, t, f);
      send_frame(f, 1'b0, st);
    end
    n_tests += 2;
    if (lbp_valid_o !== 1'b1) begin n_fail++; $display("FAIL dec_valid: got %b want 1", lbp_valid_o); end
    if (LBP_codes_o !== {E{6'h00}}) begin n_fail++; $display("FAIL dec_codes: got %h want all 00", LBP_codes_o); end
  endtask

  task automatic test_alternating();
    frame_t f;
    logic [E*L-1:0] want;
    int st;
    do_reset();
    for (int t = 0; t < L + 4; t++) begin
      gen_frame(3, t, f);
      send_frame(f, 1'b1, st);
      if (t >= L) begin
        want = ((t - L) % 2 == 0) ? {E{6'b010101}} : {E{6'b101010}};
        n_tests += 3;
        if (lbp_valid_o !== 1'b1) begin n_fail++; $display("FAIL alt_valid frame%0d: got %b want 1", t + 1, lbp_valid_o); end
        if (LBP_codes_o !== want) begin n_fail++; $display("FAIL alt_codes frame%0d: got %h want %h", t + 1, LBP_codes_o, want); end
        if (st !== 0) begin n_fail++; $display("FAIL alt_stall frame%0d: got %0d want 0", t + 1, st); end
      end
    end
  endtask

  task automatic test_random();
    frame_t f;
    int st;
    bit sep;
    do_reset();
    for (int t = 0; t < L + 7; t++) begin
      gen_frame(0, t, f);
      send_frame(f, 1'b1, st);
      if (t >= L) begin
        n_tests += 3;
        if (lbp_valid_o !== exp_valid) begin n_fail++; $display("FAIL rnd_valid frame%0d: got %b want %b", t + 1, lbp_valid_o, exp_valid); end
        if (LBP_codes_o !== exp_frame(exp_idx)) begin n_fail++; $display("FAIL rnd_codes frame%0d: got %h want %h", t + 1, LBP_codes_o, exp_frame(exp_idx)); end
        if (drop_cnt_o !== 16'(exp_drop)) begin n_fail++; $display("FAIL rnd_drop frame%0d: got %0d want %0d", t + 1, drop_cnt_o, exp_drop); end
        sep = 1'($urandom_range(0, 1));
        if (sep) begin
          pulse_consume();
          n_tests++;
          if (lbp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rnd_consume frame%0d: got %b want 0", t + 1, lbp_valid_o); end
        end
      end
    end
  endtask

`ifdef LBP_DROP_EN
  task automatic test_drop();
    frame_t f;
    int st;
    do_reset();
    for (int t = 0; t < L + 3; t++) begin
      gen_frame(0, t, f);
      send_frame(f, 1'b0, st);
      n_tests++;
      if (st !== 0) begin n_fail++; $display("FAIL drop_ready frame%0d: stalls %0d want 0", t + 1, st); end
    end
    n_tests += 3;
    if (drop_cnt_o !== 16'd2) begin n_fail++; $display("FAIL drop_cnt: got %0d want 2", drop_cnt_o); end
    if (drop_cnt_o !== 16'(exp_drop)) begin n_fail++; $display("FAIL drop_cnt_model: got %0d want %0d", drop_cnt_o, exp_drop); end
    if (LBP_codes_o !== exp_frame(L + 2)) begin n_fail++; $display("FAIL drop_newest: got %h want %h", LBP_codes_o, exp_frame(L + 2)); end
    gen_frame(0, L + 3, f);
    send_frame(f, 1'b1, st);
    n_tests += 3;
    if (drop_cnt_o !== 16'd2) begin n_fail++; $display("FAIL drop_consume_same_cycle: got %0d want 2", drop_cnt_o); end
    if (lbp_valid_o !== 1'b1) begin n_fail++; $display("FAIL drop_valid: got %b want 1", lbp_valid_o); end
    if (LBP_codes_o !== exp_frame(L + 3)) begin n_fail++; $display("FAIL drop_codes: got %h want %h", LBP_codes_o, exp_frame(L + 3)); end
  endtask
`else
  task automatic test_backpressure();
    frame_t f;
    bit acc;
    int w;
    int st;
    do_reset();
    for (int t = 0; t <= L; t++) begin
      gen_frame(0, t, f);
      send_frame(f, 1'b0, st);
    end
    gen_frame(0, L + 1, f);
    for (int c = 0; c < E - 1; c++) begin
      put_sample(f[c], 1'b0, 5, acc, w);
      n_tests++;
      if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_early_ch%0d: accepted %b want 1", c, acc); end
    end
    put_sample(f[E-1], 1'b0, 3 * E, acc, w);
    n_tests += 4;
    if (acc !== 1'b0) begin n_fail++; $display("FAIL bp_ready_ch63: accepted %b want 0", acc); end
    if (lbp_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold: got %b want 1", lbp_valid_o); end
    if (LBP_codes_o !== exp_frame(L)) begin n_fail++; $display("FAIL bp_codes_stable: got %h want %h", LBP_codes_o, exp_frame(L)); end
    if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL bp_drop: got %0d want 0", drop_cnt_o); end
    put_sample(f[E-1], 1'b1, 1, acc, w);
    note_frame(f, 1'b1);
    n_tests += 3;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_release: accepted %b want 1", acc); end
    if (lbp_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid: got %b want 1", lbp_valid_o); end
    if (LBP_codes_o !== exp_frame(L + 1)) begin n_fail++; $display("FAIL bp_release_codes: got %h want %h", LBP_codes_o, exp_frame(L + 1)); end
    gen_frame(0, L + 2, f);
    send_frame(f, 1'b1, st);
    n_tests++;
    if (LBP_codes_o !== exp_frame(L + 2)) begin n_fail++; $display("FAIL bp_no_loss: got %h want %h", LBP_codes_o, exp_frame(L + 2)); end
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ramp();
    test_decreasing();
    test_alternating();
    test_random();
`ifdef LBP_DROP_EN
    test_drop();
`else
    test_backpressure();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
